robs_mult_sequencer: RTL
========================

ROBS_MULT_SEQUENCER -- requirements
Module: robs_mult_sequencer

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; the product is 2*WIDTH bits.
REQ-002 Parameter TIMEOUT, default 32: maximum RUN cycles allowed before a job is aborted; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  upstream job request.
REQ-006 req_x, req_y  input  WIDTH each  two's-complement multiplicand and multiplier.
REQ-007 req_ready  output  1  sequencer can accept a job.
REQ-008 mul_start  output  1  active-high restart pulse to the multiplier control unit's reset.
REQ-009 mul_x, mul_y  output  WIDTH each  registered operands to the multiplier datapath.
REQ-010 mul_done  input  1  completion flag from the control unit.
REQ-011 mul_product  input  2*WIDTH  datapath product.
REQ-012 rsp_valid  output  1  result available downstream.
REQ-013 rsp_ready  input  1  downstream accepts the result.
REQ-014 rsp_product  output  2*WIDTH  captured product.
REQ-015 rsp_err  output  1  job aborted by timeout.
REQ-016 busy  output  1  sequencer not in IDLE.
REQ-017 job_count  output  8  completed-response count; wraps 255->0.

Function
REQ-018 The FSM SHALL have the states IDLE, LAUNCH, RUN and RESP.
REQ-019 IDLE: req_ready=1; on req_valid&&req_ready, latch req_x/req_y into mul_x/mul_y and go to LAUNCH.
REQ-020 LAUNCH (exactly 1 cycle): mul_start=1, watchdog cleared, then RUN.
REQ-021 mul_done SHALL be ignored in IDLE and LAUNCH, so a stale done from the previous job never completes a new job.
REQ-022 RUN: the watchdog increments once per cycle; on mul_done=1, capture mul_product into rsp_product, set rsp_err=0, go to RESP.
REQ-023 RUN: if mul_done=0 while the watchdog equals TIMEOUT-1, set rsp_product=0 and rsp_err=1, then go to RESP.
REQ-024 When mul_done and the timeout coincide in the same cycle, done SHALL win (rsp_err=0, product captured).
REQ-025 RESP: rsp_valid=1; rsp_product and rsp_err SHALL be held stable until rsp_ready=1; on handshake, increment job_count and return to IDLE.
REQ-026 req_ready SHALL be 0 in every state except IDLE; no request is accepted in the cycle a response handshakes (minimum job period = 4 cycles).
REQ-027 mul_x/mul_y SHALL hold their values from LAUNCH through RESP.
REQ-028 busy=1 in LAUNCH, RUN and RESP.
REQ-029 The total latency from request accept to rsp_valid SHALL be 2 + (RUN cycles until done).
REQ-030 All outputs SHALL be registered or decoded from state only, with no combinational path from any input to any output.

Reset
REQ-031 Asserting reset (low) SHALL immediately force IDLE and clear mul_x, mul_y, rsp_product, rsp_err, job_count and the watchdog to 0.
REQ-032 While in reset: mul_start=1, so the control unit is held in reset; rsp_valid=0; req_ready=0; busy=0.
REQ-033 A reset asserted mid-job SHALL discard the job with no response emitted and no job_count change.
REQ-034 On the first clock edge after reset deasserts, the block SHALL be in IDLE with req_ready=1 and mul_start=0.

Structure
REQ-035 The package robs_pkg SHALL hold the FSM state enum, the WIDTH and TIMEOUT defaults, and the job_count width constant.
REQ-036 The watchdog SHALL be a single sub-module, robs_timeout_counter (clear, enable, expire output), and SHALL be sized for 8 bits.
REQ-037 The block SHALL pair with the existing Robertson control unit and datapath: mul_start drives the control unit's reset, and mul_done is taken from its done output.

Verification
REQ-038 Single job: x=8'h05, y=8'hFD, mul_done after 17 RUN cycles -> rsp_valid on cycle 19 after accept, rsp_product=16'hFFF1, rsp_err=0, job_count=1.
REQ-039 Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid and rsp_product stable and req_ready=0 throughout; on release, one handshake only.
REQ-040 Timeout: mul_done never asserted, TIMEOUT=32 -> rsp_valid after 32 RUN cycles with rsp_err=1 and rsp_product=0; with mul_done on cycle 32 as well -> rsp_err=0.
REQ-041 Stale done: mul_done held at 1 from the prior job through LAUNCH -> not sampled, and the job completes only on a RUN-state done.
REQ-042 Mid-job reset: reset low during RUN -> immediate IDLE outputs, mul_start=1, no rsp_valid, job_count unchanged.
REQ-043 Wrap-around: 256 back-to-back jobs with rsp_ready=1 -> job_count returns to 0, and every consecutive accept is exactly 4 cycles apart with done on the first RUN cycle.

Source files
------------

// File: rtl/robs_pkg.sv
// Shared constants and FSM state encoding for the Robertson multiplier job sequencer.
package robs_pkg;

  localparam int unsigned ROBS_WIDTH     = 8;
  localparam int unsigned ROBS_TIMEOUT   = 32;
  localparam int unsigned ROBS_JOB_CNT_W = 8;
  localparam int unsigned ROBS_WDOG_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESP   = 2'd3
  } robs_state_t;

endpackage

// File: rtl/robs_timeout_counter.sv
// RUN-phase watchdog: cleared before each job, counts while enabled, flags the last allowed cycle.
module robs_timeout_counter
  import robs_pkg::*;
#(
  parameter int unsigned LIMIT = ROBS_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [ROBS_WDOG_W-1:0] LAST = ROBS_WDOG_W'(LIMIT - 1);

  logic [ROBS_WDOG_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expire) begin
      r_count <= r_count + ROBS_WDOG_W'(1);
    end
  end

  assign o_expire = (r_count == LAST);

endmodule

// File: rtl/robs_mult_sequencer.sv
// Job sequencer for the Robertson multiplier: accepts an operand pair, restarts the
// control unit, waits for done (or a watchdog timeout) and holds the result until taken.
module robs_mult_sequencer
  import robs_pkg::*;
#(
  parameter int unsigned WIDTH   = ROBS_WIDTH,
  parameter int unsigned TIMEOUT = ROBS_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic [WIDTH-1:0]          req_x,
  input  logic [WIDTH-1:0]          req_y,
  output logic                      req_ready,
  output logic                      mul_start,
  output logic [WIDTH-1:0]          mul_x,
  output logic [WIDTH-1:0]          mul_y,
  input  logic                      mul_done,
  input  logic [2*WIDTH-1:0]        mul_product,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [2*WIDTH-1:0]        rsp_product,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [ROBS_JOB_CNT_W-1:0] job_count
);

  robs_state_t                r_state;
  robs_state_t                w_next;
  logic                       r_req_ready;
  logic                       r_mul_start;
  logic                       r_rsp_valid;
  logic                       r_busy;
  logic [WIDTH-1:0]           r_mul_x;
  logic [WIDTH-1:0]           r_mul_y;
  logic [2*WIDTH-1:0]         r_rsp_product;
  logic                       r_rsp_err;
  logic [ROBS_JOB_CNT_W-1:0]  r_job_count;

  logic w_accept;
  logic w_rsp_fire;
  logic w_expire;
  logic w_wd_clear;
  logic w_wd_enable;

  assign w_accept    = r_req_ready && req_valid;
  assign w_rsp_fire  = (r_state == ST_RESP) && rsp_ready;
  assign w_wd_clear  = (r_state == ST_LAUNCH);
  assign w_wd_enable = (r_state == ST_RUN);

  robs_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_clear  (w_wd_clear),
    .i_enable (w_wd_enable),
    .o_expire (w_expire)
  );

  // mul_done is only looked at in RUN so a done left over from the last job is ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_next = ST_LAUNCH;
      ST_LAUNCH: w_next = ST_RUN;
      ST_RUN:    if (mul_done || w_expire) w_next = ST_RESP;
      ST_RESP:   if (rsp_ready) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they carry no input-to-output
  // path; their reset values give the "held in reset" view (mul_start high, not ready).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_req_ready   <= 1'b0;
      r_mul_start   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_mul_x       <= '0;
      r_mul_y       <= '0;
      r_rsp_product <= '0;
      r_rsp_err     <= 1'b0;
      r_job_count   <= '0;
    end else begin
      r_state     <= w_next;
      r_req_ready <= (w_next == ST_IDLE);
      r_mul_start <= (w_next == ST_LAUNCH);
      r_rsp_valid <= (w_next == ST_RESP);
      r_busy      <= (w_next != ST_IDLE);

      if (w_accept) begin
        r_mul_x <= req_x;
        r_mul_y <= req_y;
      end

      // A done in the expiring cycle still wins over the timeout.
      if (r_state == ST_RUN) begin
        if (mul_done) begin
          r_rsp_product <= mul_product;
          r_rsp_err     <= 1'b0;
        end else if (w_expire) begin
          r_rsp_product <= '0;
          r_rsp_err     <= 1'b1;
        end
      end

      if (w_rsp_fire) begin
        r_job_count <= r_job_count + ROBS_JOB_CNT_W'(1);
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign mul_start   = r_mul_start;
  assign mul_x       = r_mul_x;
  assign mul_y       = r_mul_y;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_product = r_rsp_product;
  assign rsp_err     = r_rsp_err;
  assign busy        = r_busy;
  assign job_count   = r_job_count;

endmodule
